output_channel_sequencer: RTL and testbench

- Parametrised successor to the wavelet output multiplexer: selects among NUM_CHANNELS truncated wavelet lanes and drives a single DATA_WIDTH output bus with valid/tag signalling.
- Adds sample-strobe qualification, an auto-scan mode with programmable dwell, and a burst (TDM) mode that serialises a coherent snapshot of all lanes.
- Sits between the FIR/wavelet bank outputs and the chip's output pins.

---
 rtl/output_channel_sequencer_pkg.sv | 16 +
 rtl/output_channel_sequencer_if.sv | 29 ++
 rtl/output_channel_sequencer_lane_select.sv | 28 ++
 rtl/output_channel_sequencer.sv | 172 +++++++++++++++++
 tb/tb_output_channel_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/output_channel_sequencer_pkg.sv
// Shared encodings for the output channel sequencer: operating modes and burst FSM states.
// The reserved mode value is folded onto FIXED by effective_mode().
package output_seq_pkg;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  function automatic logic [1:0] effective_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_FIXED : mode;
  endfunction

endpackage

// File: rtl/output_channel_sequencer_if.sv
// Lane inputs, control inputs and sample outputs of the output channel sequencer.
// The driver of lanes/controls uses master; the sequencer uses slave.
interface output_channel_sequencer_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SEL_WIDTH    = 8,
  parameter int DWELL_WIDTH  = 16
);
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_channels;
  logic                               i_sample_strobe;
  logic [1:0]                         i_mode;
  logic [SEL_WIDTH-1:0]               i_select_output_channel;
  logic [DWELL_WIDTH-1:0]             i_dwell;
  logic [DATA_WIDTH-1:0]              o_data;
  logic                               o_valid;
  logic [SEL_WIDTH-1:0]               o_channel;
  logic                               o_frame_start;
  logic                               o_overrun;

  modport master (
    output i_channels, i_sample_strobe, i_mode, i_select_output_channel, i_dwell,
    input  o_data, o_valid, o_channel, o_frame_start, o_overrun
  );

  modport slave (
    input  i_channels, i_sample_strobe, i_mode, i_select_output_channel, i_dwell,
    output o_data, o_valid, o_channel, o_frame_start, o_overrun
  );
endinterface

// File: rtl/output_channel_sequencer_lane_select.sv
// Combinational lane picker: 1-based index into flattened lanes, returning lane data and tag.
// Indices of 0 or beyond NUM_CHANNELS fall back to lane 0 with tag 1.
module output_lane_select #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SEL_WIDTH    = 8
) (
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] lanes,
  input  logic [SEL_WIDTH-1:0]               idx,
  output logic [DATA_WIDTH-1:0]              lane_data,
  output logic [SEL_WIDTH-1:0]               tag
);

  logic in_range;

  always_comb begin
    in_range  = (idx != '0) && (idx <= SEL_WIDTH'(NUM_CHANNELS));
    lane_data = lanes[DATA_WIDTH-1:0];
    tag       = SEL_WIDTH'(1);
    if (in_range) begin
      tag = idx;
      for (int k = 1; k < NUM_CHANNELS; k++) begin
        if (idx == SEL_WIDTH'(k + 1)) lane_data = lanes[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/output_channel_sequencer.sv
// Output channel sequencer: FIXED / SCAN / BURST selection of wavelet lanes onto one output bus.
// All outputs are registered; a strobe in cycle N yields o_valid in cycle N+1.
//
//   state    | meaning
//   ST_IDLE  | waiting for strobes; FIXED/SCAN beats emitted here, BURST start captures snapshot
//   ST_BURST | serialising snapshot; beat_q is the beat index currently on the output
module output_channel_sequencer
  import output_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SEL_WIDTH    = 8,
  parameter int DWELL_WIDTH  = 16
) (
  input logic                      clk,
  input logic                      rst,
  output_channel_sequencer_if.slave bus
);

  localparam int              CW        = $clog2(NUM_CHANNELS + 1);
  localparam logic [CW-1:0]   LAST_CH   = CW'(NUM_CHANNELS);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NUM_CHANNELS - 1);
  localparam int              LW        = NUM_CHANNELS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic [SEL_WIDTH-1:0]   channel_q, channel_d;
  logic                   frame_start_q, frame_start_d;
  logic                   overrun_q, overrun_d;
  logic [CW-1:0]          scan_ch_q, scan_ch_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic [1:0]             mode_q, mode_d;
  logic [LW-1:0]          snap_q, snap_d;

  logic [1:0]             mode_eff;
  logic                   mode_chg;
  logic [CW-1:0]          scan_eff;
  logic [DWELL_WIDTH-1:0] cnt_eff;
  logic [SEL_WIDTH-1:0]   live_idx, live_tag, snap_idx, snap_tag;
  logic [DATA_WIDTH-1:0]  live_data, snap_data;

  assign mode_eff = effective_mode(bus.i_mode);
  assign mode_chg = (bus.i_mode != mode_q);
  assign scan_eff = mode_chg ? CW'(1) : scan_ch_q;
  assign cnt_eff  = mode_chg ? '0 : dwell_cnt_q;

  // Burst starts (from IDLE or back-to-back) always emit lane 0 straight from the live input.
  always_comb begin
    live_idx = bus.i_select_output_channel;
    if (state_q == ST_BURST || mode_eff == MODE_BURST) live_idx = SEL_WIDTH'(1);
    else if (mode_eff == MODE_SCAN)                     live_idx = SEL_WIDTH'(scan_eff);
  end

  assign snap_idx = SEL_WIDTH'(beat_q) + SEL_WIDTH'(2);

  output_lane_select #(
    .NUM_CHANNELS(NUM_CHANNELS), .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) u_live_sel (
    .lanes(bus.i_channels), .idx(live_idx), .lane_data(live_data), .tag(live_tag)
  );

  output_lane_select #(
    .NUM_CHANNELS(NUM_CHANNELS), .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) u_snap_sel (
    .lanes(snap_q), .idx(snap_idx), .lane_data(snap_data), .tag(snap_tag)
  );

  always_comb begin
    data_d        = data_q;
    valid_d       = 1'b0;
    channel_d     = channel_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    scan_ch_d     = scan_ch_q;
    dwell_cnt_d   = dwell_cnt_q;
    state_d       = state_q;
    beat_d        = beat_q;
    mode_d        = mode_q;
    snap_d        = snap_q;

    case (state_q)
      ST_IDLE: begin
        mode_d      = bus.i_mode;
        scan_ch_d   = scan_eff;
        dwell_cnt_d = cnt_eff;
        if (bus.i_sample_strobe) begin
          data_d    = live_data;
          channel_d = live_tag;
          valid_d   = 1'b1;
          case (mode_eff)
            MODE_SCAN: begin
              frame_start_d = (scan_eff == CW'(1));
              if (cnt_eff == bus.i_dwell) begin
                dwell_cnt_d = '0;
                scan_ch_d   = (scan_eff == LAST_CH) ? CW'(1) : scan_eff + CW'(1);
              end else begin
                dwell_cnt_d = cnt_eff + DWELL_WIDTH'(1);
              end
            end
            MODE_BURST: begin
              frame_start_d = 1'b1;
              snap_d        = bus.i_channels;
              beat_d        = '0;
              state_d       = ST_BURST;
            end
            default: ;
          endcase
        end
      end

      ST_BURST: begin
        if (beat_q == LAST_BEAT) begin
          if (bus.i_sample_strobe) begin
            data_d        = live_data;
            channel_d     = live_tag;
            valid_d       = 1'b1;
            frame_start_d = 1'b1;
            snap_d        = bus.i_channels;
            beat_d        = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          data_d    = snap_data;
          channel_d = snap_tag;
          valid_d   = 1'b1;
          beat_d    = beat_q + CW'(1);
          if (bus.i_sample_strobe) overrun_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      channel_q     <= SEL_WIDTH'(1);
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      scan_ch_q     <= CW'(1);
      dwell_cnt_q   <= '0;
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      mode_q        <= MODE_FIXED;
      snap_q        <= '0;
    end else begin
      data_q        <= data_d;
      valid_q       <= valid_d;
      channel_q     <= channel_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      scan_ch_q     <= scan_ch_d;
      dwell_cnt_q   <= dwell_cnt_d;
      state_q       <= state_d;
      beat_q        <= beat_d;
      mode_q        <= mode_d;
      snap_q        <= snap_d;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_channel     = channel_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_overrun     = overrun_q;

endmodule

// File: tb/tb_output_channel_sequencer.sv
// Scoreboard bench: stimulus predicts every output beat (cycle, data, tag, frame start) into
// queues; a negedge monitor pops and compares whatever the sequencer presents.
module tb_output_channel_sequencer;
  import output_seq_pkg::*;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int SW = 8;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_channel_sequencer_if #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DWELL_WIDTH(WW)
  ) bus_if ();

  output_channel_sequencer #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DWELL_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  typedef struct { int due; logic [DW-1:0] data; logic [SW-1:0] tag; logic fs; } beat_t;
  typedef struct { int due; logic val; } ovr_t;

  beat_t expq[$];
  ovr_t  ovq[$];
  int    rstq[$];

  int cyc = 0;
  int vec = 0;
  int mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [DW-1:0] lanes[N];
  int            m_sc, m_cnt, m_bstart;
  logic [1:0]    m_last_mode;
  bit            m_burst, m_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_beat(input int due, input int lane, input int tag, input bit fs);
    beat_t b;
    b.due  = due;
    b.data = lanes[lane];
    b.tag  = SW'(tag);
    b.fs   = fs;
    expq.push_back(b);
  endtask

  task automatic model_step(input bit stb);
    bit busy, fin;
    int em, sel;
    if (rst) begin
      while (expq.size() > 0 && expq[expq.size()-1].due > cyc) void'(expq.pop_back());
      rstq.push_back(cyc + 1);
      ovq.push_back('{cyc + 1, 1'b0});
      m_sc = 0; m_cnt = 0; m_last_mode = MODE_FIXED; m_burst = 0; m_ovr = 0;
      return;
    end
    busy = m_burst && (cyc < m_bstart + N);
    fin  = m_burst && (cyc == m_bstart + N);
    if (!busy && !fin) begin
      m_burst = 0;
      if (bus_if.i_mode != m_last_mode) begin m_sc = 0; m_cnt = 0; end
      m_last_mode = bus_if.i_mode;
    end
    if (!stb) return;
    if (busy) begin
      if (!m_ovr) begin m_ovr = 1; ovq.push_back('{cyc + 1, 1'b1}); end
      return;
    end
    em = fin ? int'(MODE_BURST) : ((bus_if.i_mode == 2'd3) ? 0 : int'(bus_if.i_mode));
    if (em == int'(MODE_SCAN)) begin
      push_beat(cyc + 1, m_sc, m_sc + 1, m_sc == 0);
      if (m_cnt == int'(bus_if.i_dwell)) begin m_cnt = 0; m_sc = (m_sc + 1) % N; end
      else m_cnt++;
    end else if (em == int'(MODE_BURST)) begin
      for (int b = 0; b < N; b++) push_beat(cyc + 1 + b, b, b + 1, b == 0);
      m_burst = 1; m_bstart = cyc;
    end else begin
      sel = int'(bus_if.i_select_output_channel);
      if (sel >= 1 && sel <= N) push_beat(cyc + 1, sel - 1, sel, 1'b0);
      else push_beat(cyc + 1, 0, 1, 1'b0);
    end
  endtask

  task automatic tick(input bit stb);
    for (int k = 0; k < N; k++) bus_if.i_channels[k*DW +: DW] = lanes[k];
    bus_if.i_sample_strobe = stb;
    model_step(stb);
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_lanes();
    for (int k = 0; k < N; k++) lanes[k] = DW'(8'h10 + k);
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < N; k++) lanes[k] = DW'($urandom_range(0, 255));
  endtask

  // monitor
  bit            started = 0;
  logic          ovr_exp = 1'b0;
  logic [DW-1:0] last_d  = '0;
  logic [SW-1:0] last_t  = SW'(1);

  always @(negedge clk) begin
    bit is_rst;
    beat_t e;
    is_rst = 0;
    while (rstq.size() > 0 && rstq[0] < cyc) void'(rstq.pop_front());
    if (rstq.size() > 0 && rstq[0] == cyc) begin
      void'(rstq.pop_front());
      is_rst  = 1;
      started = 1;
    end
    while (ovq.size() > 0 && ovq[0].due <= cyc) begin
      ovr_exp = ovq[0].val;
      void'(ovq.pop_front());
    end
    if (started) begin
      while (expq.size() > 0 && expq[0].due < cyc) begin
        chk("stale_beat", 32'(expq[0].due), 32'(cyc));
        void'(expq.pop_front());
      end
      if (is_rst) begin
        chk("rst_valid", 32'(bus_if.o_valid), 32'd0);
        chk("rst_data", 32'(bus_if.o_data), 32'd0);
        chk("rst_channel", 32'(bus_if.o_channel), 32'd1);
        chk("rst_frame_start", 32'(bus_if.o_frame_start), 32'd0);
        last_d = '0;
        last_t = SW'(1);
      end else if (bus_if.o_valid) begin
        if (expq.size() == 0 || expq[0].due != cyc) begin
          chk("unexpected_valid", 32'(bus_if.o_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("data", 32'(bus_if.o_data), 32'(e.data));
          chk("channel", 32'(bus_if.o_channel), 32'(e.tag));
          chk("frame_start", 32'(bus_if.o_frame_start), 32'(e.fs));
          last_d = e.data;
          last_t = e.tag;
        end
      end else begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
          chk("missing_valid", 32'(bus_if.o_valid), 32'd1);
          void'(expq.pop_front());
        end
        chk("hold_data", 32'(bus_if.o_data), 32'(last_d));
        chk("hold_channel", 32'(bus_if.o_channel), 32'(last_t));
        chk("idle_frame_start", 32'(bus_if.o_frame_start), 32'd0);
      end
      chk("overrun", 32'(bus_if.o_overrun), 32'(ovr_exp));
    end
  end

  initial begin
    ramp_lanes();
    bus_if.i_mode = MODE_FIXED;
    bus_if.i_select_output_channel = SW'(3);
    bus_if.i_dwell = '0;
    bus_if.i_sample_strobe = 1'b0;
    bus_if.i_channels = '0;
    rst = 1'b1;
    repeat (3) tick(1'b1);
    rst = 1'b0;
    repeat (6) tick(1'b1);

    // FIXED out-of-range selects, then random selects and lanes
    bus_if.i_select_output_channel = SW'(0);
    tick(1'b1); repeat (3) tick(1'b0);
    bus_if.i_select_output_channel = SW'(17);
    tick(1'b1); repeat (3) tick(1'b0);
    repeat (40) begin
      bus_if.i_select_output_channel = SW'($urandom_range(0, 20));
      rand_lanes();
      tick(1'($urandom_range(0, 1)));
    end

    // SCAN, dwell 1, strobe every 4 cycles
    ramp_lanes();
    bus_if.i_mode = MODE_SCAN;
    bus_if.i_dwell = WW'(1);
    repeat (34) begin tick(1'b1); repeat (3) tick(1'b0); end

    // SCAN with random dwell and strobes, then reserved mode
    bus_if.i_dwell = WW'($urandom_range(0, 3));
    repeat (80) begin rand_lanes(); tick($urandom_range(0, 2) == 0); end
    bus_if.i_mode = 2'd3;
    bus_if.i_select_output_channel = SW'($urandom_range(1, N));
    repeat (10) tick(1'($urandom_range(0, 1)));

    // BURST: lanes change right after the strobe; snapshot must hold the old values
    ramp_lanes();
    bus_if.i_mode = MODE_BURST;
    tick(1'b0);
    tick(1'b1);
    rand_lanes();
    repeat (20) tick(1'b0);

    // early strobe at beat 5 is dropped, strobe on the final beat chains a new burst
    ramp_lanes();
    tick(1'b1);
    repeat (5) tick(1'b0);
    tick(1'b1);
    repeat (9) tick(1'b0);
    rand_lanes();
    tick(1'b1);
    repeat (20) tick(1'b0);

    // reset during beat 7 aborts the burst
    ramp_lanes();
    tick(1'b1);
    repeat (7) tick(1'b0);
    rst = 1'b1;
    repeat (2) tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    tick(1'b1);
    repeat (20) tick(1'b0);

    // random bursts with occasional early strobes
    repeat (8) begin
      int gap, early;
      rand_lanes();
      tick(1'b1);
      gap   = $urandom_range(N - 1, N + 6);
      early = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N - 2) : -1;
      for (int g = 1; g <= gap; g++) tick(g == early);
    end
    repeat (20) tick(1'b0);

    // back to SCAN with random stimulus
    bus_if.i_mode = MODE_SCAN;
    bus_if.i_dwell = WW'($urandom_range(0, 2));
    repeat (30) begin rand_lanes(); tick(1'($urandom_range(0, 1))); end
    repeat (20) tick(1'b0);

    chk("drain", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
